step_ctrl: RTL and testbench

- Parametrised front-panel input conditioner and CPU step-clock generator for the tiny CPU board top.
- Synchronises and debounces WIDTH raw button/switch lines and provides per-channel level, rise and fall pulses.
- Derives a single-cycle CPU clock enable in two modes: manual single-step on a chosen channel, or free-run at a programmable divide rate.
- Sits between board pins and tinycpu. Adds mode selection, a run divider, halt gating and edge outputs that a plain debouncer lacks.

---
 rtl/step_ctrl.sv | 166 ++++++++++++++++
 tb/tb_step_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/step_ctrl.sv
// step_ctrl: front-panel input conditioner and CPU step-clock generator.
// Per channel: 2-flop synchroniser, counter debouncer, rise/fall pulses.
// CPU clock enable: manual single-step on channel STEP_CH, or free-run at
// div+1 cycles per pulse; halt gates both modes.
// Optional build macro STEP_AUTOREPEAT_EN adds hold-to-repeat stepping.
module step_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned STEP_CH    = 0,
  parameter int unsigned DIV_W      = 24,
  parameter int unsigned REPEAT_DLY = 25000000,
  parameter int unsigned REPEAT_PER = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  input  logic             run_mode,
  input  logic [DIV_W-1:0] div,
  input  logic             halt,
  output logic             cpu_ce,
  output logic             cpu_clk
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [DEB_W-1:0] r_cnt [WIDTH];
  logic [DEB_W-1:0] w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_out_nxt;

  logic             r_mode_q;
  logic [DIV_W-1:0] r_dcnt;
  logic [DIV_W-1:0] w_dcnt_nxt;
  logic             w_mode_chg;
  logic             w_fire;
  logic             w_rep_fire;

  // Two-flop synchroniser for the asynchronous pins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= in;
      r_sync <= r_meta;
    end
  end

  // Debounce next state: count while sync differs, commit on the last count
  always_comb begin
    w_out_nxt = out;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_cnt_nxt[i] = '0;
      if (r_sync[i] != out[i]) begin
        if (r_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          w_out_nxt[i] = r_sync[i];
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Debounced level, edge pulses and counters, all updated on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out  <= '0;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      out  <= w_out_nxt;
      rise <= w_out_nxt & ~out;
      fall <= ~w_out_nxt & out;
      for (int i = 0; i < int'(WIDTH); i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign w_mode_chg = run_mode ^ r_mode_q;

`ifdef STEP_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX) + 1;

  logic [RPT_W-1:0] r_rcnt;
  logic             r_rep_on;
  logic [RPT_W-1:0] w_rcnt_nxt;
  logic             w_rep_on_nxt;

  // Hold-to-repeat: first repeat after REPEAT_DLY, then every REPEAT_PER
  always_comb begin
    w_rcnt_nxt   = r_rcnt + RPT_W'(1);
    w_rep_on_nxt = r_rep_on;
    w_rep_fire   = 1'b0;
    if (run_mode || w_mode_chg || !out[STEP_CH]) begin
      w_rcnt_nxt   = '0;
      w_rep_on_nxt = 1'b0;
    end else if ((!r_rep_on && (r_rcnt == RPT_W'(REPEAT_DLY - 1))) ||
                 ( r_rep_on && (r_rcnt == RPT_W'(REPEAT_PER - 1)))) begin
      w_rcnt_nxt   = '0;
      w_rep_on_nxt = 1'b1;
      w_rep_fire   = 1'b1;
    end
  end

  // Repeat counter state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rcnt   <= '0;
      r_rep_on <= 1'b0;
    end else begin
      r_rcnt   <= w_rcnt_nxt;
      r_rep_on <= w_rep_on_nxt;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // CPU enable decision: mode change wins, then free-run divider or step
  always_comb begin
    w_dcnt_nxt = r_dcnt;
    w_fire     = 1'b0;
    if (w_mode_chg) begin
      w_dcnt_nxt = '0;
    end else if (run_mode) begin
      if (!halt) begin
        if (r_dcnt == div) begin
          w_dcnt_nxt = '0;
          w_fire     = 1'b1;
        end else begin
          w_dcnt_nxt = r_dcnt + DIV_W'(1);
        end
      end
    end else begin
      w_dcnt_nxt = '0;
      w_fire     = (rise[STEP_CH] | w_rep_fire) & ~halt;
    end
  end

  // Divider, mode history, registered enable and toggling CPU clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode_q <= 1'b0;
      r_dcnt   <= '0;
      cpu_ce   <= 1'b0;
      cpu_clk  <= 1'b0;
    end else begin
      r_mode_q <= run_mode;
      r_dcnt   <= w_dcnt_nxt;
      cpu_ce   <= w_fire;
      if (w_fire) begin
        cpu_clk <= ~cpu_clk;
      end
    end
  end

endmodule

// File: tb/tb_step_ctrl.sv
// Directed bench for step_ctrl (DEB_CYCLES=4, STEP_CH=0, DIV_W=4).
module tb_step_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] in;
  logic [7:0] out;
  logic [7:0] rise;
  logic [7:0] fall;
  logic       run_mode;
  logic [3:0] div;
  logic       halt;
  logic       cpu_ce;
  logic       cpu_clk;

  int n_chk;
  int n_err;
  int ce_cnt;
  logic [7:0] rise_acc;
  logic [7:0] fall_acc;

  step_ctrl #(
    .WIDTH(8), .DEB_CYCLES(4), .STEP_CH(0), .DIV_W(4),
    .REPEAT_DLY(20), .REPEAT_PER(8)
  ) dut (
    .clk(clk), .reset(reset), .in(in), .out(out), .rise(rise), .fall(fall),
    .run_mode(run_mode), .div(div), .halt(halt), .cpu_ce(cpu_ce), .cpu_clk(cpu_clk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges, sampling 1 time unit after each edge
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rise_acc = rise_acc | rise;
      fall_acc = fall_acc | fall;
      if (cpu_ce) ce_cnt++;
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0; ce_cnt = 0; rise_acc = '0; fall_acc = '0;
    reset = 1'b0; in = '0; run_mode = 1'b0; div = '0; halt = 1'b0;
    #2;
    chk("rst_out",     32'(out), 32'h0);
    chk("rst_rise",    32'(rise), 32'h0);
    chk("rst_fall",    32'(fall), 32'h0);
    chk("rst_ce",      32'(cpu_ce), 32'h0);
    chk("rst_cpu_clk", 32'(cpu_clk), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    run(2);

    // Clean step on channel 3
    in[3] = 1'b1;
    run(5);
    chk("clean_out_early", 32'(out), 32'h00);
    run(1);
    chk("clean_out",  32'(out), 32'h08);
    chk("clean_rise", 32'(rise), 32'h08);
    chk("clean_fall", 32'(fall), 32'h00);
    run(1);
    chk("clean_rise_1cyc", 32'(rise), 32'h00);
    chk("clean_no_ce", 32'(cpu_ce), 32'h0);

    // Bounce on channel 0, then a clean hold (also a single step)
    rise_acc = '0; fall_acc = '0; ce_cnt = 0;
    in[0] = 1'b1; run(2);
    in[0] = 1'b0; run(2);
    in[0] = 1'b1; run(2);
    in[0] = 1'b0; run(2);
    in[0] = 1'b1;
    run(5);
    chk("bounce_out_early", 32'(out), 32'h08);
    chk("bounce_no_rise",   32'(rise_acc), 32'h00);
    run(1);
    chk("bounce_out",  32'(out), 32'h09);
    chk("bounce_rise", 32'(rise), 32'h01);
    run(1);
    chk("bounce_rise_1cyc", 32'(rise), 32'h00);
    chk("step_ce",      32'(cpu_ce), 32'h1);
    chk("step_cpu_clk", 32'(cpu_clk), 32'h1);
    ce_cnt = 0;
    run(30);
    chk("step_held_no_ce", 32'(ce_cnt), 32'd0);
    chk("bounce_no_fall",  32'(fall_acc), 32'h00);
    in[0] = 1'b0;
    run(6);
    chk("release_out",  32'(out), 32'h08);
    chk("release_fall", 32'(fall), 32'h01);
    run(1);

    // Step press with halt high: no enable
    halt = 1'b1; ce_cnt = 0;
    in[0] = 1'b1;
    run(6);
    chk("halt_rise", 32'(rise), 32'h01);
    run(1);
    chk("halt_no_ce",  32'(cpu_ce), 32'h0);
    chk("halt_cpu_clk", 32'(cpu_clk), 32'h1);
    run(5);
    chk("halt_ce_cnt", 32'(ce_cnt), 32'd0);
    halt = 1'b0;
    in[0] = 1'b0;
    run(8);

    // Second clean step
    ce_cnt = 0;
    in[0] = 1'b1;
    run(7);
    chk("step2_ce",      32'(cpu_ce), 32'h1);
    chk("step2_cpu_clk", 32'(cpu_clk), 32'h0);
    run(20);
    chk("step2_ce_cnt", 32'(ce_cnt), 32'd1);
    in[0] = 1'b0;
    run(8);

    // Free-run, div=3: pulse every 4 cycles after the mode-change cycle
    run_mode = 1'b1; div = 4'd3;
    for (int k = 1; k <= 14; k++) begin
      run(1);
      chk($sformatf("frun_k%0d", k), 32'(cpu_ce),
          32'((k >= 5) && (((k - 5) % 4) == 0)));
    end
    // Halt with dcnt=1 held for 10 cycles, then resume from 1
    halt = 1'b1; ce_cnt = 0;
    run(10);
    chk("frun_halt_cnt", 32'(ce_cnt), 32'd0);
    halt = 1'b0;
    run(1); chk("resume_1", 32'(cpu_ce), 32'h0);
    run(1); chk("resume_2", 32'(cpu_ce), 32'h0);
    run(1); chk("resume_3", 32'(cpu_ce), 32'h1);
    // div=0: enable every cycle
    div = 4'd0;
    for (int k = 1; k <= 5; k++) begin
      run(1);
      chk($sformatf("div0_k%0d", k), 32'(cpu_ce), 32'h1);
    end
    // Switch to step mode mid-period, then back: count restarts at 0
    div = 4'd3;
    run(2);
    run_mode = 1'b0;
    run(1); chk("modechg_ce", 32'(cpu_ce), 32'h0);
    run(1); chk("step_idle_ce", 32'(cpu_ce), 32'h0);
    run_mode = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      run(1);
      chk($sformatf("rerun_k%0d", k), 32'(cpu_ce), 32'(k == 5));
    end

    // Long hold in step mode: exactly one enable
    run_mode = 1'b0;
    run(2);
    ce_cnt = 0;
    in[0] = 1'b1;
    run(60);
    in[0] = 1'b0;
    run(20);
    chk("hold_ce_cnt",  32'(ce_cnt), 32'd1);
    chk("hold_out",     32'(out), 32'h08);
    chk("hold_cpu_clk", 32'(cpu_clk), 32'h1);

    // Reset while all outputs high
    in = 8'hFF;
    run(8);
    chk("all_high", 32'(out), 32'hFF);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_out",  32'(out), 32'h00);
    chk("mid_rst_rise", 32'(rise), 32'h00);
    chk("mid_rst_fall", 32'(fall), 32'h00);
    chk("mid_rst_ce",   32'(cpu_ce), 32'h0);
    chk("mid_rst_clk",  32'(cpu_clk), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    chk("in_rst_out", 32'(out), 32'h00);
    reset = 1'b1;
    rise_acc = '0;
    run(5);
    chk("post_rst_out_early", 32'(out), 32'h00);
    chk("post_rst_no_rise",   32'(rise_acc), 32'h00);
    run(1);
    chk("post_rst_out",  32'(out), 32'hFF);
    chk("post_rst_rise", 32'(rise), 32'hFF);
    run(1);
    chk("post_rst_ce",   32'(cpu_ce), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
